instr_issue_unit: RTL and testbench



---
 rtl/cpu19_pkg.sv | 46 ++++
 rtl/instr_fifo.sv | 93 +++++++++
 rtl/instr_issue_unit.sv | 184 ++++++++++++++++++
 tb/tb_instr_issue_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu19_pkg.sv
// -----------------------------------------------------------------------------
// cpu19_pkg
// Shared definitions for the 19-bit CPU instruction format: field widths,
// opcode values, the issue-FSM state type and opcode classification helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu19_pkg;

    localparam int INSTR_W = 19;
    localparam int OP_W    = 5;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 14;

    localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_JMP   = 5'b01010;
    localparam logic [OP_W-1:0] OP_JEQ   = 5'b01011;
    localparam logic [OP_W-1:0] OP_JNE   = 5'b01100;
    localparam logic [OP_W-1:0] OP_CALL  = 5'b01101;
    localparam logic [OP_W-1:0] OP_RET   = 5'b01110;
    localparam logic [OP_W-1:0] OP_LOAD  = 5'b01111;
    localparam logic [OP_W-1:0] OP_STORE = 5'b10000;
    localparam logic [OP_W-1:0] OP_FFT   = 5'b10001;
    localparam logic [OP_W-1:0] OP_ENC   = 5'b10010;
    localparam logic [OP_W-1:0] OP_DEC   = 5'b10011;
    localparam logic [OP_W-1:0] OP_NOP   = 5'b11111;

    // Unassigned opcode range between the last defined op and NOP.
    localparam logic [OP_W-1:0] OP_ILLEGAL_LO = 5'b10100;
    localparam logic [OP_W-1:0] OP_ILLEGAL_HI = 5'b11110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUBBLE = 2'd2
    } issue_state_e;

    // Control-flow ops occupy the contiguous range JMP..RET.
    function automatic logic is_ctrl_op(input logic [OP_W-1:0] op);
        return (op >= OP_JMP) && (op <= OP_RET);
    endfunction

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op >= OP_ILLEGAL_LO) && (op <= OP_ILLEGAL_HI);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Synchronous single-clock FIFO holding encoded instructions.
// Ports:
//   clk, rst         clock, synchronous active-high reset (control only)
//   push_i, wdata_i  write request and data (ignored when full)
//   pop_i            read request (ignored when empty); head is rdata_o
//   flush_i          empties the FIFO; overrides a same-edge push/pop
//   rdata_o          current head entry (valid when !empty_o)
//   full_o, empty_o  occupancy flags
//   count_o          occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// -----------------------------------------------------------------------------
module instr_fifo
    import cpu19_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = INSTR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_issue_unit.sv
// -----------------------------------------------------------------------------
// instr_issue_unit
// Front-end that packs host-supplied instruction fields into the 19-bit core
// format, buffers them in instr_fifo and issues one per cycle, driving NOPs
// when empty/stalled and a fixed number of bubble NOPs after control flow.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      push handshake (in_ready = !full)
//   in_fmt                   0 = register form, 1 = immediate form
//   in_opcode, in_r1..in_r3, in_imm   instruction fields
//   run                      issue enable
//   flush                    discard buffered instructions and pending bubbles
//   instruction              registered instruction to the core
//   instr_valid              instruction holds a real FIFO entry
//   count                    FIFO occupancy
//   err                      sticky illegal-opcode flag
// Build option: define ILLEGAL_OP_CHECK_EN to drop pushes with opcodes in
// 10100..11110 and raise err; otherwise all opcodes are enqueued, err = 0.
// -----------------------------------------------------------------------------
module instr_issue_unit
    import cpu19_pkg::*;
#(
    parameter int              DEPTH   = 8,
    parameter int              BUBBLES = 2,
    parameter logic [OP_W-1:0] NOP_OP  = OP_NOP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_fmt,
    input  logic [OP_W-1:0]             in_opcode,
    input  logic [REG_W-1:0]            in_r1,
    input  logic [REG_W-1:0]            in_r2,
    input  logic [REG_W-1:0]            in_r3,
    input  logic [IMM_W-1:0]            in_imm,
    input  logic                        run,
    input  logic                        flush,
    output logic [INSTR_W-1:0]          instruction,
    output logic                        instr_valid,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        err
);

    localparam int CNT_W = $clog2(DEPTH+1);
    // Keep the bubble counter at least one bit wide even when BUBBLES = 0.
    localparam int BUB_W = (BUBBLES > 0) ? $clog2(BUBBLES+1) : 1;
    localparam logic [INSTR_W-1:0] NOP_WORD = {NOP_OP, {IMM_W{1'b0}}};

    issue_state_e          state_q, state_d;
    logic [BUB_W-1:0]      bub_cnt_q, bub_cnt_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;

    logic [INSTR_W-1:0]    push_word;
    logic                  handshake;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [INSTR_W-1:0]    fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [OP_W-1:0]       head_op;

    // Encoding is fixed here, at push time.
    always_comb begin
        if (in_fmt) begin
            push_word = {in_opcode, in_imm};
        end else begin
            push_word = {in_opcode, in_r1, in_r2, in_r3, 2'b00};
        end
    end

    assign in_ready  = !fifo_full;
    assign handshake = in_valid && in_ready;
    assign head_op   = fifo_head[INSTR_W-1 -: OP_W];

`ifdef ILLEGAL_OP_CHECK_EN
    logic illegal_push;
    logic err_q;

    // Illegal pushes still complete the handshake; they are simply not stored.
    assign illegal_push = handshake && is_illegal_op(in_opcode);
    assign fifo_push    = handshake && !illegal_push;
    assign err          = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (illegal_push) begin
            err_q <= 1'b1;
        end
    end
`else
    assign fifo_push = handshake;
    assign err       = 1'b0;
`endif

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (push_word),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Issue FSM. A pop happens on the same edge the head is registered onto
    // `instruction`, so IDLE pops directly instead of waiting a cycle in ISSUE;
    // this gives the one-edge push-to-issue latency.
    always_comb begin
        state_d       = state_q;
        bub_cnt_d     = bub_cnt_q;
        instr_d       = NOP_WORD;
        instr_valid_d = 1'b0;
        fifo_pop      = 1'b0;

        if (flush) begin
            state_d   = IDLE;
            bub_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE, ISSUE: begin
                    if (run && !fifo_empty) begin
                        fifo_pop      = 1'b1;
                        instr_d       = fifo_head;
                        instr_valid_d = 1'b1;
                        if (is_ctrl_op(head_op) && (BUBBLES > 0)) begin
                            state_d   = BUBBLE;
                            bub_cnt_d = BUB_W'(BUBBLES);
                        end else if ((fifo_count > CNT_W'(1)) || fifo_push) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUBBLE: begin
                    // With run low the bubble countdown freezes in place.
                    if (run) begin
                        if (bub_cnt_q <= BUB_W'(1)) begin
                            bub_cnt_d = '0;
                            state_d   = (!fifo_empty || fifo_push) ? ISSUE : IDLE;
                        end else begin
                            bub_cnt_d = bub_cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bub_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bub_cnt_q     <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bub_cnt_q     <= bub_cnt_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = instr_valid_q;
    assign count       = fifo_count;

endmodule

// File: tb/tb_instr_issue_unit.sv
module tb_instr_issue_unit;

    localparam int          DEPTH   = 8;
    localparam int          BUBBLES = 2;
    localparam logic [18:0] NOP_W   = 19'h7C000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_fmt;
    logic [4:0]  in_opcode;
    logic [3:0]  in_r1, in_r2, in_r3;
    logic [13:0] in_imm;
    logic        run;
    logic        flush;
    logic [18:0] instruction;
    logic        instr_valid;
    logic [3:0]  count;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    instr_issue_unit #(
        .DEPTH   (DEPTH),
        .BUBBLES (BUBBLES),
        .NOP_OP  (5'b11111)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt      (in_fmt),
        .in_opcode   (in_opcode),
        .in_r1       (in_r1),
        .in_r2       (in_r2),
        .in_r3       (in_r3),
        .in_imm      (in_imm),
        .run         (run),
        .flush       (flush),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .count       (count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [18:0] enc(input logic fmt, input logic [4:0] op,
                                        input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [13:0] imm);
        if (fmt) return {op, imm};
        return {op, a, b, c, 2'b00};
    endfunction

    function automatic bit is_ctrl(input logic [4:0] op);
        return (op >= 5'd10) && (op <= 5'd14);
    endfunction

    function automatic bit is_bad(input logic [4:0] op);
`ifdef ILLEGAL_OP_CHECK_EN
        return (op >= 5'd20) && (op <= 5'd30);
`else
        return (op == 5'd0) && (op != 5'd0);
`endif
    endfunction

    logic [18:0] mq[$];     // model of buffered entries
    logic [18:0] sb[$];     // scoreboard: entries expected to be issued, in order
    int          gap;       // remaining bubble cycles owed
    logic [18:0] m_instr;
    logic        m_valid;
    logic        m_err;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit          acc;
        logic [18:0] w;
        if (rst) begin
            mq.delete();
            sb.delete();
            gap     = 0;
            m_instr = NOP_W;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            w   = enc(in_fmt, in_opcode, in_r1, in_r2, in_r3, in_imm);
            if (acc && is_bad(in_opcode)) m_err = 1'b1;
            if (flush) begin
                mq.delete();
                sb.delete();
                gap     = 0;
                m_instr = NOP_W;
                m_valid = 1'b0;
            end else begin
                if (gap > 0) begin
                    m_instr = NOP_W;
                    m_valid = 1'b0;
                    if (run) gap--;
                end else if (run && mq.size() > 0) begin
                    m_instr = mq.pop_front();
                    m_valid = 1'b1;
                    if (is_ctrl(m_instr[18:14])) gap = BUBBLES;
                end else begin
                    m_instr = NOP_W;
                    m_valid = 1'b0;
                end
                if (acc && !is_bad(in_opcode)) begin
                    mq.push_back(w);
                    sb.push_back(w);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("instruction", 32'(instruction), 32'(m_instr));
            check("count", 32'(count), 32'(mq.size()));
            check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            check("err", 32'(err), 32'(m_err));
            if (instr_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    check("issue_order", 32'(instruction), 32'(sb.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit v, input bit fmt, input logic [4:0] op,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [13:0] imm, input bit rn, input bit fl);
        in_valid  = v;
        in_fmt    = fmt;
        in_opcode = op;
        in_r1     = a;
        in_r2     = b;
        in_r3     = c;
        in_imm    = imm;
        run       = rn;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rn);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 14'd0, rn, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_fmt = 0; in_opcode = 0; in_r1 = 0; in_r2 = 0;
        in_r3 = 0; in_imm = 0; run = 0; flush = 0;
        chk_en = 1'b1;
        idle(2, 1'b0);
        rst = 1'b0;

        // Reset / idle state
        idle(1, 1'b1);
        check("rst_instruction", 32'(instruction), 32'h7C000);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);

        // Register form: two edges to issue, then NOP
        step(1, 0, 5'b00000, 4'd1, 4'd2, 4'd3, 14'd0, 1, 0);
        idle(1, 1'b1);
        check("regform_instr", 32'(instruction), 32'h0048C);
        check("regform_valid", 32'(instr_valid), 32'd1);
        idle(1, 1'b1);
        check("regform_after", 32'(instruction), 32'h7C000);

        // Control flow followed by two bubbles
        step(1, 1, 5'b01111, 4'd0, 4'd0, 4'd0, 14'd5, 1, 0);
        step(1, 1, 5'b01010, 4'd0, 4'd0, 4'd0, 14'h10, 1, 0);
        check("seq0", 32'(instruction), 32'h3C005);
        step(1, 1, 5'b01111, 4'd0, 4'd0, 4'd0, 14'd5, 1, 0);
        check("seq1", 32'(instruction), 32'h28010);
        idle(1, 1'b1);
        check("seq2_bubble", 32'(instruction), 32'h7C000);
        idle(1, 1'b1);
        check("seq3_bubble", 32'(instruction), 32'h7C000);
        idle(1, 1'b1);
        check("seq4", 32'(instruction), 32'h3C005);
        idle(2, 1'b1);

        // Fill with run low, refuse a 9th push, then drain in order
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, 5'(i), 4'(i), 4'(i + 1), 4'(i + 2), 14'd0, 0, 0);
        check("full_count", 32'(count), 32'd8);
        check("full_ready", 32'(in_ready), 32'd0);
        step(1, 1, 5'b00001, 4'd0, 4'd0, 4'd0, 14'h3FFF, 0, 0);
        check("refused_count", 32'(count), 32'd8);
        idle(DEPTH + 2, 1'b1);
        check("drain_count", 32'(count), 32'd0);

        // Flush with a same-edge push
        for (int i = 0; i < 3; i++)
            step(1, 1, 5'b00010, 4'd0, 4'd0, 4'd0, 14'(100 + i), 0, 0);
        step(1, 1, 5'b00011, 4'd0, 4'd0, 4'd0, 14'd7, 1, 1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(instr_valid), 32'd0);
        idle(4, 1'b1);

        // Illegal-opcode range
        step(1, 1, 5'b10100, 4'd0, 4'd0, 4'd0, 14'd0, 0, 0);
`ifdef ILLEGAL_OP_CHECK_EN
        check("illegal_count", 32'(count), 32'd0);
        check("illegal_err", 32'(err), 32'd1);
        idle(3, 1'b1);
        check("illegal_err_sticky", 32'(err), 32'd1);
`else
        check("illegal_count", 32'(count), 32'd1);
        check("illegal_err", 32'(err), 32'd0);
        idle(3, 1'b1);
`endif
        do_reset();
        idle(1, 1'b0);
        check("err_after_rst", 32'(err), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 60,
                 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(10, 14)) : 5'($urandom_range(0, 31)),
                 4'($urandom), 4'($urandom), 4'($urandom), 14'($urandom),
                 $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 2);
        end
        idle(40, 1'b1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
